// File: rtl/systolic_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_sequencer
//   Runs one pass of a MAT_DIM x MAT_DIM systolic MAC array. It accepts a
//   matrix pair, pulses a clear to the PE accumulators, feeds skewed row and
//   column edge operands, waits for the array to drain, then snapshots the
//   array result and holds it until the consumer takes it.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   in_valid/in_ready host handshake for mat1_in (A) / mat2_in (B)
//   mat1_in, mat2_in  packed operand matrices, element [0][0] in the MSBs
//   abort             synchronous cancel of the pass in flight
//   arr_clear         one-cycle clear to every PE accumulator
//   a_feed, b_feed    row / column edge operands, lane i at [i*DATA_SIZE +:]
//   arr_result        live accumulators from the array, packed like mat1_in
//   out_valid/out_ready consumer handshake for result_out
//   result_out        registered snapshot of arr_result
//   busy              high whenever a pass is in progress
// -----------------------------------------------------------------------------

// One feed lane: at step s it presents A[LANE][s-LANE] on the row edge and
// B[s-LANE][LANE] on the column edge, or zero outside the skew window.
module systolic_skew_lane #(
    parameter int MAT_DIM   = 3,
    parameter int DATA_SIZE = 8,
    parameter int CW        = 3,
    parameter int LANE      = 0
) (
    input  logic                              en,
    input  logic [CW-1:0]                     step,
    input  logic [MAT_DIM-1:0][DATA_SIZE-1:0] a_row,  // A[LANE][k]
    input  logic [MAT_DIM-1:0][DATA_SIZE-1:0] b_col,  // B[k][LANE]
    output logic [DATA_SIZE-1:0]              a_out,
    output logic [DATA_SIZE-1:0]              b_out
);
    always_comb begin
        a_out = '0;
        b_out = '0;
        if (en) begin
            for (int k = 0; k < MAT_DIM; k++) begin
                if (step == CW'(LANE + k)) begin
                    a_out = a_row[k];
                    b_out = b_col[k];
                end
            end
        end
    end
endmodule

module systolic_sequencer #(
    parameter int MAT_DIM      = 3,
    parameter int DATA_SIZE    = 8,
    parameter int ACC_SIZE     = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [MAT_DIM*MAT_DIM*DATA_SIZE-1:0]  mat1_in,
    input  logic [MAT_DIM*MAT_DIM*DATA_SIZE-1:0]  mat2_in,
    input  logic                                  abort,
    output logic                                  arr_clear,
    output logic [MAT_DIM*DATA_SIZE-1:0]          a_feed,
    output logic [MAT_DIM*DATA_SIZE-1:0]          b_feed,
    input  logic [MAT_DIM*MAT_DIM*ACC_SIZE-1:0]   arr_result,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [MAT_DIM*MAT_DIM*ACC_SIZE-1:0]   result_out,
    output logic                                  busy
);
    localparam int NE      = MAT_DIM * MAT_DIM;
    localparam int STEPS   = 2 * MAT_DIM - 1;
    localparam int CNT_MAX = (STEPS > DRAIN_CYCLES) ? STEPS : DRAIN_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] LAST_STEP  = CW'(STEPS - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_HOLD} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic                accept, capture;
    logic                clear_nxt, feed_en, valid_nxt;
    logic [NE*DATA_SIZE-1:0] mat_a, mat_b;

    logic [MAT_DIM-1:0][MAT_DIM-1:0][DATA_SIZE-1:0] a_rows;  // [r][c] = A[r][c]
    logic [MAT_DIM-1:0][MAT_DIM-1:0][DATA_SIZE-1:0] b_cols;  // [c][r] = B[r][c]
    logic [MAT_DIM-1:0][DATA_SIZE-1:0]              a_nxt, b_nxt;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state; the counter restarts at 0 on every state entry
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        accept  = 1'b0;
        capture = 1'b0;
        case (state)
            S_IDLE: begin
                // abort outranks a simultaneous request
                if (in_valid && !abort) begin
                    accept  = 1'b1;
                    state_n = S_CLEAR;
                end
            end
            S_CLEAR: state_n = abort ? S_IDLE : S_FEED;
            S_FEED: begin
                if (abort)                  state_n = S_IDLE;
                else if (cnt == LAST_STEP)  state_n = S_DRAIN;
                else                        cnt_n   = cnt + 1'b1;
            end
            S_DRAIN: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (cnt == LAST_DRAIN) begin
                    state_n = S_HOLD;
                    capture = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_HOLD:  if (abort || out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs: handshake flags decode the current state; everything else is
    // registered from the next state so it lines up with that state's cycle.
    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state != S_IDLE);
        clear_nxt = (state_n == S_CLEAR);
        feed_en   = (state_n == S_FEED);
        valid_nxt = (state_n == S_HOLD);
    end

    for (genvar r = 0; r < MAT_DIM; r++) begin : g_row
        for (genvar c = 0; c < MAT_DIM; c++) begin : g_col
            assign a_rows[r][c] = mat_a[(NE-1-(r*MAT_DIM+c))*DATA_SIZE +: DATA_SIZE];
            assign b_cols[c][r] = mat_b[(NE-1-(r*MAT_DIM+c))*DATA_SIZE +: DATA_SIZE];
        end
    end

    for (genvar l = 0; l < MAT_DIM; l++) begin : g_lane
        systolic_skew_lane #(
            .MAT_DIM   (MAT_DIM),
            .DATA_SIZE (DATA_SIZE),
            .CW        (CW),
            .LANE      (l)
        ) u_lane (
            .en    (feed_en),
            .step  (cnt_n),
            .a_row (a_rows[l]),
            .b_col (b_cols[l]),
            .a_out (a_nxt[l]),
            .b_out (b_nxt[l])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arr_clear  <= 1'b0;
            a_feed     <= '0;
            b_feed     <= '0;
            out_valid  <= 1'b0;
            result_out <= '0;
            mat_a      <= '0;
            mat_b      <= '0;
        end else begin
            arr_clear <= clear_nxt;
            a_feed    <= a_nxt;
            b_feed    <= b_nxt;
            out_valid <= valid_nxt;
            // result_out survives an abort; only a completed drain replaces it
            if (capture) result_out <= arr_result;
            if (accept) begin
                mat_a <= mat1_in;
                mat_b <= mat2_in;
            end
        end
    end
endmodule

// File: tb/tb_systolic_sequencer.sv
// -----------------------------------------------------------------------------
// tb_systolic_sequencer
//   Directed bench for systolic_sequencer with a behavioural 3x3 systolic MAC
//   array closing the loop. Expected products come from a plain matrix
//   multiply pushed to a queue at acceptance and popped when out_valid rises.
// -----------------------------------------------------------------------------
module tb_systolic_sequencer;
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [71:0]   mat1_in = '0;
    logic [71:0]   mat2_in = '0;
    logic          in_ready, arr_clear, out_valid, busy;
    logic [23:0]   a_feed, b_feed;
    logic [143:0]  arr_result, result_out;

    int errors = 0;
    int checks = 0;
    logic [143:0] sb[$];
    logic [143:0] last_res = '0;

    always #5 clk = ~clk;

    systolic_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mat1_in    (mat1_in),
        .mat2_in    (mat2_in),
        .abort      (abort),
        .arr_clear  (arr_clear),
        .a_feed     (a_feed),
        .b_feed     (b_feed),
        .arr_result (arr_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_out (result_out),
        .busy       (busy)
    );

    // Behavioural output-stationary array: A moves right, B moves down.
    logic [7:0]  ar [3][3];
    logic [7:0]  br [3][3];
    logic [15:0] acc[3][3];
    logic [7:0]  a_in[3][3];
    logic [7:0]  b_in[3][3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                a_in[i][j] = (j == 0) ? a_feed[i*8 +: 8] : ar[i][(j == 0) ? 0 : j-1];
                b_in[i][j] = (i == 0) ? b_feed[j*8 +: 8] : br[(i == 0) ? 0 : i-1][j];
            end
        end
    end

    always_comb begin
        arr_result = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                arr_result[(8-(i*3+j))*16 +: 16] = acc[i][j];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (arr_clear) begin
                    acc[i][j] <= '0;
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                end else begin
                    acc[i][j] <= acc[i][j] + {8'd0, a_in[i][j]} * {8'd0, b_in[i][j]};
                    ar[i][j]  <= a_in[i][j];
                    br[i][j]  <= b_in[i][j];
                end
            end
        end
    end

    function automatic logic [7:0] elem(input logic [71:0] m, input int r, input int c);
        return m[(8-(r*3+c))*8 +: 8];
    endfunction

    function automatic logic [143:0] matmul(input logic [71:0] a, input logic [71:0] b);
        logic [143:0] res;
        logic [15:0]  sum;
        res = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                sum = '0;
                for (int k = 0; k < 3; k++)
                    sum = sum + {8'd0, elem(a, i, k)} * {8'd0, elem(b, k, j)};
                res[(8-(i*3+j))*16 +: 16] = sum;
            end
        end
        return res;
    endfunction

    function automatic logic [23:0] feed_a(input logic [71:0] m, input int s);
        logic [23:0] v;
        v = '0;
        for (int r = 0; r < 3; r++)
            if (s - r >= 0 && s - r < 3) v[r*8 +: 8] = elem(m, r, s - r);
        return v;
    endfunction

    function automatic logic [23:0] feed_b(input logic [71:0] m, input int s);
        logic [23:0] v;
        v = '0;
        for (int c = 0; c < 3; c++)
            if (s - c >= 0 && s - c < 3) v[c*8 +: 8] = elem(m, s - c, c);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "/in_ready"},  in_ready,  1'b1);
        chk({tag, "/busy"},      busy,      1'b0);
        chk({tag, "/out_valid"}, out_valid, 1'b0);
        chk({tag, "/arr_clear"}, arr_clear, 1'b0);
        chk({tag, "/a_feed"},    a_feed,    24'd0);
        chk({tag, "/b_feed"},    b_feed,    24'd0);
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE after the
    // result handshake. hold = cycles out_ready stays low once out_valid is up.
    task automatic run_pass(input logic [71:0] a, input logic [71:0] b,
                            input int hold, input string tag);
        logic [143:0] exp;
        mat1_in   = a;
        mat2_in   = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        sb.push_back(matmul(a, b));
        chk({tag, "/accept_rdy"}, in_ready, 1'b1);
        @(negedge clk);                       // cycle 1
        in_valid = 1'b0;
        chk({tag, "/c1_clear"}, arr_clear, 1'b1);
        chk({tag, "/c1_busy"},  busy,      1'b1);
        chk({tag, "/c1_rdy"},   in_ready,  1'b0);
        chk({tag, "/c1_afeed"}, a_feed,    24'd0);
        for (int s = 0; s < 5; s++) begin     // cycles 2..6
            @(negedge clk);
            chk($sformatf("%s/feed_a_s%0d", tag, s), a_feed, feed_a(a, s));
            chk($sformatf("%s/feed_b_s%0d", tag, s), b_feed, feed_b(b, s));
            chk($sformatf("%s/clear_s%0d", tag, s), arr_clear, 1'b0);
        end
        for (int d = 0; d < 4; d++) begin     // cycles 7..10
            @(negedge clk);
            chk($sformatf("%s/drain_a%0d", tag, d), a_feed, 24'd0);
            chk($sformatf("%s/drain_b%0d", tag, d), b_feed, 24'd0);
            chk($sformatf("%s/drain_ov%0d", tag, d), out_valid, 1'b0);
        end
        @(negedge clk);                       // cycle 11
        chk({tag, "/c11_valid"}, out_valid, 1'b1);
        exp = sb.pop_front();
        chk({tag, "/result"},    result_out, exp);
        chk({tag, "/copy"},      result_out, arr_result);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;                  // must be ignored while busy
            mat1_in  = ~a;
            mat2_in  = ~b;
            @(negedge clk);
            chk($sformatf("%s/hold%0d_ov", tag, h),  out_valid,  1'b1);
            chk($sformatf("%s/hold%0d_res", tag, h), result_out, exp);
            chk($sformatf("%s/hold%0d_rdy", tag, h), in_ready,   1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_idle({tag, "/post"});
        chk({tag, "/post_res"}, result_out, exp);
        last_res = exp;
    endtask

    initial begin
        logic [71:0] ident, seq, ff, ones, ra, rb;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                ident[(8-(i*3+j))*8 +: 8] = (i == j) ? 8'd1 : 8'd0;
                seq  [(8-(i*3+j))*8 +: 8] = 8'(i*3 + j + 1);
            end
        ff   = {9{8'hFF}};
        ones = {9{8'h01}};

        // Reset state
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset/result", result_out, 144'd0);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("idle");

        // abort in IDLE wins over in_valid
        in_valid = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        chk_idle("idle_abort");

        // Identity x [1..9], then all-255 back to back, then a held result
        run_pass(ident, seq, 0, "ident");
        chk("ident/value", last_res, {16'd1,16'd2,16'd3,16'd4,16'd5,16'd6,16'd7,16'd8,16'd9});
        run_pass(ff, ff, 0, "ff");
        chk("ff/wrap", result_out[15:0], 16'd64003);
        ra = {$urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom};
        run_pass(ra, rb, 5, "hold");

        // abort at FEED step 2
        ra = {$urandom, $urandom, $urandom};
        mat1_in  = ra;
        mat2_in  = ra;
        in_valid = 1'b1;
        @(negedge clk);                       // cycle 1
        in_valid = 1'b0;
        repeat (3) @(negedge clk);            // cycle 4, step 2
        chk("abort/step2", a_feed, feed_a(ra, 2));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort");
        chk("abort/result_kept", result_out, last_res);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("abort/quiet%0d", i), out_valid, 1'b0);
        end
        run_pass(ones, ones, 0, "ones");
        chk("ones/value", last_res, {9{16'd3}});

        // reset mid-DRAIN
        ra = {$urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom};
        mat1_in  = ra;
        mat2_in  = rb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);            // cycle 8, DRAIN
        chk("rst_mid/busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk_idle("rst_mid");
        chk("rst_mid/result", result_out, 144'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_pass({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 0, "b2b_1");
        run_pass({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 0, "b2b_2");

        chk("sb_empty", 144'(sb.size()), 144'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
